pipeline_stall_ctrl: RTL and testbench

//   Central stall/freeze controller for the 5-stage pipeline. Drives the freeze inputs of
//   the IF/ID/EX/MEM pipeline registers and the EX bubble select. Sequences multi-cycle

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_stall_ctrl_hazard_detect.sv | 26 ++
 rtl/pipeline_stall_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// The state encoding is fixed so the FSM state can be observed by debug tooling.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 3;
  localparam int REG_ZERO       = 0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source operands in ID.
// Register zero is hardwired, so a load targeting it never creates a dependency.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_used,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_load,
  output logic                  lu
);

  logic dest_nz;
  logic src1_hit;
  logic src2_hit;

  assign dest_nz  = (ex_dest != REG_ADDR_W'(REG_ZERO));
  assign src1_hit = id_src1_used && (id_src1 == ex_dest);
  assign src2_hit = id_src2_used && (id_src2 == ex_dest);
  assign lu       = ex_load && dest_nz && (src1_hit || src2_hit);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central freeze/bubble controller: sequences multi-cycle MEM accesses, inserts
// load-use bubbles and keeps saturating stall statistics plus a sticky timeout flag.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_used,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_load,
  input  logic                  mem_access,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  freeze_if,
  output logic                  freeze_id,
  output logic                  freeze_ex,
  output logic                  freeze_mem,
  output logic                  bubble_ex,
  output logic                  mem_timeout_err,
  output logic [CNT_W-1:0]      lu_stall_cnt,
  output logic [CNT_W-1:0]      mem_stall_cnt
);

  localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]  ms_cnt_q, ms_cnt_d;

  logic lu;
  logic mem_stall;
  logic lu_apply;
  logic req_c, fif_c, fid_c, fex_c, fmem_c, bub_c, err_c;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .ex_dest      (ex_dest),
    .ex_load      (ex_load),
    .lu           (lu)
  );

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_stall = 1'b0;
    lu_apply  = 1'b0;
    req_c     = 1'b0;
    fif_c     = 1'b0;
    fid_c     = 1'b0;
    fex_c     = 1'b0;
    fmem_c    = 1'b0;
    bub_c     = 1'b0;
    err_c     = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        req_c     = mem_access;
        mem_stall = mem_access && !mem_ack;
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        req_c     = mem_access;
        mem_stall = mem_access && !mem_ack;
        // A dropped access (flush) releases the wait just like an ack does.
        if (!mem_stall) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_ERR: begin
        fif_c  = 1'b1;
        fid_c  = 1'b1;
        fex_c  = 1'b1;
        fmem_c = 1'b1;
        err_c  = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    if (mem_stall) begin
      fif_c  = 1'b1;
      fid_c  = 1'b1;
      fex_c  = 1'b1;
      fmem_c = 1'b1;
    end else if (lu && (state_q != ST_ERR)) begin
      lu_apply = 1'b1;
      fif_c    = 1'b1;
      fid_c    = 1'b1;
      bub_c    = 1'b1;
    end

    lu_cnt_d = (lu_apply && (lu_cnt_q != CNT_MAX)) ? lu_cnt_q + 1'b1 : lu_cnt_q;
    ms_cnt_d = (mem_stall && (ms_cnt_q != CNT_MAX)) ? ms_cnt_q + 1'b1 : ms_cnt_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      wait_q   <= '0;
      lu_cnt_q <= '0;
      ms_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      lu_cnt_q <= lu_cnt_d;
      ms_cnt_q <= ms_cnt_d;
    end
  end

  // Outputs are held low for the whole reset window, whatever the inputs do.
  assign mem_req         = rst && req_c;
  assign freeze_if       = rst && fif_c;
  assign freeze_id       = rst && fid_c;
  assign freeze_ex       = rst && fex_c;
  assign freeze_mem      = rst && fmem_c;
  assign bubble_ex       = rst && bub_c;
  assign mem_timeout_err = rst && err_c;
  assign lu_stall_cnt    = rst ? lu_cnt_q : '0;
  assign mem_stall_cnt   = rst ? ms_cnt_q : '0;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench: two controller instances (default and small-counter/long-timeout)
// driven in lockstep and compared every cycle against a behavioural stall model.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_src1, id_src2, ex_dest;
  logic       id_src1_used, id_src2_used, ex_load, mem_access, mem_ack;

  logic        a_req, a_fif, a_fid, a_fex, a_fmem, a_bub, a_err;
  logic [15:0] a_lu, a_ms;
  logic        b_req, b_fif, b_fid, b_fex, b_fmem, b_bub, b_err;
  logic [3:0]  b_lu, b_ms;

  localparam int TMO  [2] = '{15, 31};
  localparam int CMAX [2] = '{65535, 15};

  int total = 0;
  int bad   = 0;

  // Model state: timeout flag, length of the current stall burst, statistics.
  bit m_err  [2];
  int m_wait [2];
  int m_lu   [2];
  int m_ms   [2];

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut_a (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .ex_dest(ex_dest), .ex_load(ex_load),
    .mem_access(mem_access), .mem_ack(mem_ack),
    .mem_req(a_req), .freeze_if(a_fif), .freeze_id(a_fid), .freeze_ex(a_fex),
    .freeze_mem(a_fmem), .bubble_ex(a_bub), .mem_timeout_err(a_err),
    .lu_stall_cnt(a_lu), .mem_stall_cnt(a_ms)
  );

  pipeline_stall_ctrl #(.REG_ADDR_W(3), .MEM_TIMEOUT(31), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .ex_dest(ex_dest), .ex_load(ex_load),
    .mem_access(mem_access), .mem_ack(mem_ack),
    .mem_req(b_req), .freeze_if(b_fif), .freeze_id(b_fid), .freeze_ex(b_fex),
    .freeze_mem(b_fmem), .bubble_ex(b_bub), .mem_timeout_err(b_err),
    .lu_stall_cnt(b_lu), .mem_stall_cnt(b_ms)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flag vector order: {mem_req, freeze_if, freeze_id, freeze_ex, freeze_mem, bubble_ex, err}
  function automatic logic [6:0] dut_flags(input int k);
    if (k == 0) return {a_req, a_fif, a_fid, a_fex, a_fmem, a_bub, a_err};
    return {b_req, b_fif, b_fid, b_fex, b_fmem, b_bub, b_err};
  endfunction

  function automatic logic [31:0] dut_lu(input int k);
    return (k == 0) ? 32'(a_lu) : 32'(b_lu);
  endfunction

  function automatic logic [31:0] dut_ms(input int k);
    return (k == 0) ? 32'(a_ms) : 32'(b_ms);
  endfunction

  // Expected outputs for the current cycle, then advance the model across the clock edge.
  task automatic model_step(input int k, output logic [6:0] f);
    bit lu;
    lu = ex_load && (ex_dest != 3'd0) &&
         ((id_src1_used && id_src1 == ex_dest) || (id_src2_used && id_src2 == ex_dest));
    if (m_err[k]) begin
      f = 7'b0111101;
    end else if (mem_access && !mem_ack) begin
      f = 7'b1111100;
      if (m_ms[k] < CMAX[k]) m_ms[k]++;
      m_wait[k]++;
      if (m_wait[k] > TMO[k]) m_err[k] = 1'b1;
    end else begin
      m_wait[k] = 0;
      f = {mem_access, 6'b000000};
      if (lu) begin
        f[5] = 1'b1;
        f[4] = 1'b1;
        f[1] = 1'b1;
        if (m_lu[k] < CMAX[k]) m_lu[k]++;
      end
    end
  endtask

  task automatic run_cycle();
    logic [6:0] f;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("lu_cnt[%0d]", k), dut_lu(k), 32'(m_lu[k]));
      check($sformatf("ms_cnt[%0d]", k), dut_ms(k), 32'(m_ms[k]));
      model_step(k, f);
      check($sformatf("flags[%0d]", k), 32'(dut_flags(k)), 32'(f));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit acc, input bit ack, input bit load, input int dest,
                       input int s1, input int s2, input bit u1, input bit u2);
    mem_access   = acc;
    mem_ack      = ack;
    ex_load      = load;
    ex_dest      = 3'(dest);
    id_src1      = 3'(s1);
    id_src2      = 3'(s2);
    id_src1_used = u1;
    id_src2_used = u2;
    run_cycle();
  endtask

  // Reset is asserted with hazard and pending-memory inputs active to prove output gating.
  task automatic do_reset();
    mem_access = 1'b1; mem_ack = 1'b0; ex_load = 1'b1; ex_dest = 3'd5;
    id_src1 = 3'd5; id_src1_used = 1'b1; id_src2 = 3'd0; id_src2_used = 1'b0;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_flags[%0d]", k), 32'(dut_flags(k)), 32'd0);
      check($sformatf("rst_lu[%0d]", k), dut_lu(k), 32'd0);
      check($sformatf("rst_ms[%0d]", k), dut_ms(k), 32'd0);
      m_err[k] = 1'b0; m_wait[k] = 0; m_lu[k] = 0; m_ms[k] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    {id_src1, id_src2, ex_dest} = '0;
    {id_src1_used, id_src2_used, ex_load, mem_access, mem_ack} = '0;
    @(negedge clk);
    do_reset();

    // Zero-wait memory accesses.
    repeat (3) drive(1, 1, 0, 0, 0, 0, 0, 0);
    #1 check("zero_wait_ms", 32'(a_ms), 32'd0);

    // Three-cycle memory access: two stall cycles, released on the ack cycle.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("mem3_ms", 32'(a_ms), 32'd2);

    // Load-use on src2, then the same pattern against register zero.
    do_reset();
    drive(0, 0, 1, 3, 1, 3, 0, 1);
    drive(0, 0, 0, 3, 1, 3, 0, 1);
    drive(0, 0, 1, 0, 0, 0, 1, 1);
    #1 check("lu_single", 32'(a_lu), 32'd1);

    // Load-use masked by a pending access, applied once the ack arrives.
    do_reset();
    drive(1, 0, 1, 4, 4, 2, 1, 1);
    drive(1, 0, 1, 4, 4, 2, 1, 1);
    #1 check("lu_masked", 32'(a_lu), 32'd0);
    drive(1, 1, 1, 4, 4, 2, 1, 1);
    drive(0, 0, 0, 4, 4, 2, 1, 1);
    #1 check("lu_after_ack", 32'(a_lu), 32'd1);
    check("ms_after_ack", 32'(a_ms), 32'd2);

    // Timeout: MEM_TIMEOUT+1 stall cycles lead to a sticky error.
    do_reset();
    repeat (17) drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("timeout_err", 32'(a_err), 32'd1);
    drive(1, 1, 1, 2, 2, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Saturation of the 4-bit counter over 20 stall cycles.
    repeat (20) drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("sat_ms_b", 32'(b_ms), 32'd15);
    do_reset();

    // Random traffic with periodic resets.
    for (int n = 0; n < 600; n++) begin
      int d;
      if (n % 150 == 149) do_reset();
      d = $urandom_range(0, 7);
      drive($urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 1), d,
            ($urandom_range(0, 1) != 0) ? d : $urandom_range(0, 7),
            ($urandom_range(0, 1) != 0) ? d : $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
